// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW
// requests into accesses to a word-addressed data memory. Sub-word stores are done
// as read-modify-write; misaligned or illegal requests are flagged and dropped.
module mem_access_unit #(
    parameter int unsigned LEN_DATA = 32,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_load,
    input  logic                req_store,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [31:0]         req_addr,
    input  logic [LEN_DATA-1:0] req_wdata,
    output logic [LEN_DATA-1:0] rdata,
    output logic                rdata_valid,
    output logic                err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [LEN_DATA-1:0] mem_wdata,
    output logic                mem_wr,
    output logic                mem_rd,
    input  logic [LEN_DATA-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StLdWait, StRmw} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          off_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [15:0]         wdata_q;
    logic [LEN_DATA-1:0] rdata_q;
    logic                rdata_valid_q;
    logic                err_q;

    logic                xfer;
    logic                bad;
    logic                do_load;
    logic                do_store;
    logic                store_word;
    logic                rd;
    logic                wr;
    logic [LEN_DATA-1:0] shifted;
    logic [LEN_DATA-1:0] load_val;
    logic [LEN_DATA-1:0] merged;

    // Upper address bits are ignored so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:ADDR_W+2]};

    assign req_ready  = (state_q == StIdle);
    assign xfer       = req_valid & req_ready;
    assign do_load    = xfer & ~bad & req_load;
    assign do_store   = xfer & ~bad & req_store;
    assign store_word = (req_size == 2'b10);

    // Illegal size, misalignment, or simultaneous load+store.
    always_comb begin
        bad = (req_size == 2'b11) || (req_load && req_store) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state: loads wait one cycle for read data, sub-word stores do one RMW cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (do_load)                     state_d = StLdWait;
                else if (do_store && !store_word) state_d = StRmw;
            end
            default: state_d = StIdle;
        endcase
    end

    // Latch request fields on every accepted transfer for use in the second cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else if (xfer) begin
            addr_q  <= req_addr[ADDR_W+1:2];
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata[15:0];
        end
    end

    // Lane extraction for loads and lane merge for read-modify-write.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
        merged = mem_rdata;
        if (size_q == 2'b00) merged[{off_q, 3'b000} +: 8]        = wdata_q[7:0];
        else                 merged[{off_q[1], 4'b0000} +: 16]   = wdata_q;
    end

    // Memory-side outputs.
    always_comb begin
        rd        = 1'b0;
        wr        = 1'b0;
        mem_addr  = req_addr[ADDR_W+1:2];
        mem_wdata = req_wdata;
        case (state_q)
            StIdle: begin
                rd = do_load | (do_store & ~store_word);
                wr = do_store & store_word;
            end
            StRmw: begin
                wr        = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merged;
            end
            default: mem_addr = addr_q;
        endcase
    end

    // Strobes are forced low while reset is held so a dropped RMW never writes.
    assign mem_rd = rd & rst_n;
    assign mem_wr = wr & rst_n;

    // Registered load result and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rdata_valid_q <= (state_q == StLdWait);
            err_q         <= xfer & bad;
            if (state_q == StLdWait) rdata_q <= load_val;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// multi-cycle sequences, and random operations checked against a byte-array model.
module tb_mem_access_unit;

    localparam int ADDR_W = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_load = 1'b0;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.LEN_DATA(32), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata)
    );

    // Data memory: writes on falling edge, registered read.
    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          wr_count = 0;

    always @(negedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    // Reference model: byte-addressed memory of 256 bytes (64 words).
    logic [7:0] rb [256];

    function automatic logic [31:0] ref_word(int wa);
        return {rb[4*wa+3], rb[4*wa+2], rb[4*wa+1], rb[4*wa]};
    endfunction

    function automatic logic [31:0] ref_load(int ba, logic [1:0] sz, logic uns);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = 32'(rb[ba]);
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            v = 32'(rb[ba]) + 32'(rb[ba+1]) * 256;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = ref_word(ba / 4);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        chk(name, 32'(got), 32'(exp));
    endtask

    // One request, starting just after a rising edge; returns just after a rising edge.
    task automatic do_op(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd_o, output logic err_o);
        int          ba;
        int          wa;
        logic        bad;
        logic        sw;
        logic [31:0] exp_rd;
        ba  = int'(addr[7:0]);
        wa  = ba / 4;
        bad = (sz == 2'b11) || (ld && st) || (sz == 2'b01 && ba % 2 != 0) ||
              (sz == 2'b10 && ba % 4 != 0);
        sw  = !bad && st && sz == 2'b10;
        exp_rd = ref_load(ba, sz, uns);
        rd_o = '0;
        req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        chk1("accept_ready", req_ready, 1'b1);
        chk1("accept_mem_rd", mem_rd, !bad && (ld || (st && sz != 2'b10)));
        chk1("accept_mem_wr", mem_wr, sw);
        if (!bad && (ld || st)) chk("accept_mem_addr", 32'(mem_addr), 32'(wa));
        if (sw) chk("sw_wdata", mem_wdata, wd);
        @(posedge clk); #1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        err_o = err;
        chk1("err_pulse", err, bad);
        if (bad) begin
            chk1("err_no_rd", mem_rd, 1'b0);
            chk1("err_no_wr", mem_wr, 1'b0);
            chk1("err_ready", req_ready, 1'b1);
        end else if (sw) begin
            for (int k = 0; k < 4; k++) rb[4*wa+k] = wd[8*k +: 8];
        end
        if (bad || !ld) chk1("no_rvalid", rdata_valid, 1'b0);
        if (!bad && ld) begin
            chk1("ld_busy", req_ready, 1'b0);
            chk1("ld_wait_valid", rdata_valid, 1'b0);
            chk1("ld_wait_wr", mem_wr, 1'b0);
            @(posedge clk); #1;
            chk1("ld_rvalid", rdata_valid, 1'b1);
            chk1("ld_ready_back", req_ready, 1'b1);
            chk("ld_rdata", rdata, exp_rd);
            rd_o = rdata;
        end else if (!bad && st && sz != 2'b10) begin
            if (sz == 2'b00) rb[ba] = wd[7:0];
            else begin rb[ba] = wd[7:0]; rb[ba+1] = wd[15:8]; end
            chk1("rmw_busy", req_ready, 1'b0);
            chk1("rmw_wr", mem_wr, 1'b1);
            chk1("rmw_rd", mem_rd, 1'b0);
            chk("rmw_addr", 32'(mem_addr), 32'(wa));
            chk("rmw_wdata", mem_wdata, ref_word(wa));
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(logic ld, logic st, logic [1:0] sz, logic uns,
                                logic [31:0] addr, logic [31:0] wd, logic chk_rd,
                                logic [31:0] exp_rd, logic exp_err);
        vec_t v;
        v.ld = ld; v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [18];
        logic [31:0] rd_v;
        logic        err_v;
        logic [31:0] r;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        ld;
        logic        st;
        int          wc0;

        tbl[0]  = mk(0, 1, 2'b10, 0, 32'h4, 32'hDEADBEEF, 0, 32'h0, 0);
        tbl[1]  = mk(1, 0, 2'b10, 0, 32'h4, 32'h0, 1, 32'hDEADBEEF, 0);
        tbl[2]  = mk(1, 0, 2'b00, 0, 32'h7, 32'h0, 1, 32'hFFFFFFDE, 0);
        tbl[3]  = mk(1, 0, 2'b00, 1, 32'h7, 32'h0, 1, 32'h000000DE, 0);
        tbl[4]  = mk(1, 0, 2'b01, 0, 32'h6, 32'h0, 1, 32'hFFFFDEAD, 0);
        tbl[5]  = mk(1, 0, 2'b01, 1, 32'h4, 32'h0, 1, 32'h0000BEEF, 0);
        tbl[6]  = mk(1, 0, 2'b00, 0, 32'h4, 32'h0, 1, 32'hFFFFFFEF, 0);
        tbl[7]  = mk(0, 1, 2'b00, 0, 32'h5, 32'h12, 0, 32'h0, 0);
        tbl[8]  = mk(1, 0, 2'b10, 0, 32'h4, 32'h0, 1, 32'hDEAD12EF, 0);
        tbl[9]  = mk(0, 1, 2'b01, 0, 32'h6, 32'hCAFE, 0, 32'h0, 0);
        tbl[10] = mk(1, 0, 2'b10, 0, 32'h4, 32'h0, 1, 32'hCAFE12EF, 0);
        tbl[11] = mk(1, 0, 2'b01, 0, 32'h5, 32'h0, 0, 32'h0, 1);
        tbl[12] = mk(0, 1, 2'b10, 0, 32'h6, 32'h11111111, 0, 32'h0, 1);
        tbl[13] = mk(1, 0, 2'b11, 0, 32'h4, 32'h0, 0, 32'h0, 1);
        tbl[14] = mk(1, 1, 2'b10, 0, 32'h4, 32'h22222222, 0, 32'h0, 1);
        tbl[15] = mk(1, 0, 2'b10, 1, 32'h4, 32'h0, 1, 32'hCAFE12EF, 0);
        tbl[16] = mk(1, 0, 2'b01, 0, 32'h106, 32'h0, 1, 32'hFFFFCAFE, 0);
        tbl[17] = mk(0, 0, 2'b10, 0, 32'h8, 32'h33333333, 0, 32'h0, 0);

        // Preload memory and model identically; word 1 starts at zero.
        for (int i = 0; i < 64; i++) begin
            pl_addr = 6'(i);
            pl_data = (i == 1) ? 32'h0 : (32'(i) * 32'h9E3779B9) ^ 32'h13572468;
            for (int k = 0; k < 4; k++) rb[4*i+k] = pl_data[8*k +: 8];
            pl_en = 1'b1;
            @(negedge clk); #1;
        end
        pl_en = 1'b0;

        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_rvalid", rdata_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk1("rst_mem_rd", mem_rd, 1'b0);
        chk1("rst_mem_wr", mem_wr, 1'b0);

        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 18; i++) begin
            do_op(tbl[i].ld, tbl[i].st, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
                  rd_v, err_v);
            chk1($sformatf("vec%0d_err", i), err_v, tbl[i].exp_err);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd_v, tbl[i].exp_rd);
        end

        // Back-to-back word stores, including a wrapping address.
        wc0 = wr_count;
        do_op(0, 1, 2'b10, 0, 32'h0, 32'hA0A0A0A0, rd_v, err_v);
        do_op(0, 1, 2'b10, 0, 32'h4, 32'hA1A1A1A1, rd_v, err_v);
        do_op(0, 1, 2'b10, 0, 32'h8, 32'hA2A2A2A2, rd_v, err_v);
        do_op(0, 1, 2'b10, 0, 32'hC, 32'hA3A3A3A3, rd_v, err_v);
        @(negedge clk);
        chk("sw_burst_writes", 32'(wr_count - wc0), 32'd4);
        @(posedge clk); #1;
        do_op(0, 1, 2'b10, 0, 32'h100, 32'h5A5A5A5A, rd_v, err_v);
        @(negedge clk);
        chk("wrap_word0", mem[0], 32'h5A5A5A5A);
        @(posedge clk); #1;

        // Reset during the RMW cycle of SB 0x5 drops the write.
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'b00;
        req_addr = 32'h5; req_wdata = 32'h77;
        @(negedge clk);
        chk1("rmwrst_rd", mem_rd, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_store = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("rmwrst_wr", mem_wr, 1'b0);
        chk1("rmwrst_ready", req_ready, 1'b1);
        chk1("rmwrst_rvalid", rdata_valid, 1'b0);
        chk("rmwrst_rdata", rdata, 32'h0);
        chk1("rmwrst_err", err, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("rmwrst_ready_after", req_ready, 1'b1);
        chk("rmwrst_word", mem[1], ref_word(1));

        // Random operations against the byte model.
        for (int i = 0; i < 300; i++) begin
            r  = $urandom;
            ld = r[0];
            st = r[1];
            sz = r[3:2];
            a  = $urandom;
            if (!ld && !st) begin
                sz = 2'b10;
                a  = a & 32'hFFFFFFFC;
            end else if (r[5:4] != 2'b00) begin
                if (sz == 2'b01) a = a & 32'hFFFFFFFE;
                if (sz == 2'b10) a = a & 32'hFFFFFFFC;
                if (sz == 2'b11 && r[6]) sz = 2'b00;
            end
            do_op(ld, st, sz, r[7], a, $urandom, rd_v, err_v);
        end

        // Final memory image must match the model.
        @(negedge clk);
        for (int i = 0; i < 64; i++) chk($sformatf("final_word%0d", i), mem[i], ref_word(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit for the MIPS MEM stage, sitting directly upstream of the word-addressed data memory. It converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses. Loads are byte-lane extracted and sign- or zero-extended. Sub-word stores are performed as a read-modify-write sequence. Misaligned accesses are flagged and suppressed.

Parameters:
LEN_DATA, 32, data width; fixed at 32 for lane logic.
ADDR_W, 6, word-address width driven to memory (64 words).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept; transfer = req_valid & req_ready.
req_load  in  1  load request.
req_store  in  1  store request.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  in  1  zero-extend load result (LBU/LHU).
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned.
rdata  out  32  extended load result.
rdata_valid  out  1  one-cycle pulse; rdata is valid.
err  out  1  one-cycle pulse on a misaligned or illegal request.
mem_addr  out  ADDR_W  word address to memory.
mem_wdata  out  32  write word.
mem_wr  out  1  memory write enable; memory writes on the falling edge of the same cycle.
mem_rd  out  1  memory read enable; memory registers data at the rising edge, and mem_rdata is valid the next cycle.
mem_rdata  in  32  memory read word.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, rdata=0, rdata_valid=0, err=0. mem_rd and mem_wr are gated to 0 while rst_n=0. req_ready=1.
- States: IDLE, LD_WAIT, RMW. req_ready=1 only in IDLE.
- Address mapping: mem_addr = req_addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap. Byte offset off = req_addr[1:0].
- Lane order is little-endian: byte k = bits 8k+7:8k.
- Error check, on a transfer: a request is in error if it is a half access with off[0]=1, a word access with off≠0, req_size=11, or req_load&req_store. On error: no mem_rd/mem_wr, err=1 next cycle, remain in IDLE.
- A transfer with neither load nor store is a no-op.
- LW/LH/LB, accepted in cycle T (IDLE):
  - T: mem_rd=1 and mem_addr driven combinationally; latch off, size and unsigned; go to LD_WAIT.
  - T+1 (LD_WAIT): extract the lane from mem_rdata; register rdata and rdata_valid=1 at the end of T+1; return to IDLE.
  - T+2: rdata_valid=1 and req_ready=1.
  - Sign-extend from bit 7/15 unless unsigned. LW ignores req_unsigned.
- SW, accepted in cycle T:
  - mem_wr=1 in T, with mem_wdata=req_wdata and mem_addr combinational.
  - Stay in IDLE, so word stores sustain one per cycle.
- SB/SH, accepted in cycle T:
  - T: mem_rd=1; latch the word address, off, size and wdata; go to RMW.
  - T+1: mem_wr=1 with mem_addr = latched address and mem_wdata = mem_rdata with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]; return to IDLE.
- mem_rd and mem_wr are never both 1 in the same cycle.
- Outside a transfer or an RMW write, mem_wr=0 and mem_rd=0.
- Reset asserted mid-LD_WAIT or mid-RMW: the operation is dropped. No write occurs and no rdata_valid is produced.
- Throughput: SW 1/cycle; loads and sub-word stores 1 per 2 cycles.

Test Plan:
1. Preload word1=0. SW addr 0x4, data 0xDEADBEEF -> mem_wr=1 and mem_addr=1 in the accept cycle, req_ready stays 1. Then LW 0x4 -> rdata_valid two cycles after accept, rdata=0xDEADBEEF.
2. Word1=0xDEADBEEF, sub-word loads -> rdata values:
   - LB 0x7 -> 0xFFFFFFDE
   - LBU 0x7 -> 0x000000DE
   - LH 0x6 -> 0xFFFFDEAD
   - LHU 0x4 -> 0x0000BEEF
   - LB 0x4 -> 0xFFFFFFEF
3. SB 0x5 data 0x12 over 0xDEADBEEF -> req_ready=0 for one cycle; mem_wr in T+1 with mem_wdata=0xDEAD12EF. A following LW 0x4 returns 0xDEAD12EF. SH 0x6 data 0xCAFE then gives 0xCAFE12EF.
4. LH 0x5, SW 0x6 and req_size=11 -> err pulse the next cycle, mem_rd=mem_wr=0, no rdata_valid, memory unchanged.
5. SW to addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles -> four writes in four cycles, req_ready constantly 1. Address 0x100 writes word 0 (wrap).
6. Assert rst_n=0 during the RMW cycle of SB 0x5 -> no mem_wr, word unchanged, outputs at reset values, req_ready=1 after release.
